// File: rtl/multi_mode_accum_adder.sv
// multi_mode_accum_adder: registered add / subtract / accumulate / load datapath
// with a valid/ready handshake on both sides, a running accumulator and a
// wrapping count of accepted operations. Each result appears one cycle after
// the operand pair is accepted.
//
// Optional build macro: MULTI_MODE_ACCUM_ADDER_SATURATE_EN
//   defined   -> ADD/SUB/ACC results saturate instead of wrapping
//   undefined -> modular wrap (default)
module multi_mode_accum_adder #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 carry,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

`ifdef MULTI_MODE_ACCUM_ADDER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Result clamp: replaces a wrapped result by its limit on over/underflow
    // when saturation is built in.
    function automatic logic [WIDTH-1:0] sat_sum(input logic             ovf,
                                                 input logic [WIDTH-1:0] wrapped,
                                                 input logic [WIDTH-1:0] limit);
        return (SAT_EN && ovf) ? limit : wrapped;
    endfunction

    // Accumulator clamp: pins the accumulator at full scale on overflow.
    function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic                 ovf,
                                                     input logic [ACC_WIDTH-1:0] wrapped);
        return (SAT_EN && ovf) ? {ACC_WIDTH{1'b1}} : wrapped;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [ACC_WIDTH-1:0] ext_a, ext_b;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   acc_w;
    logic [ACC_WIDTH-1:0] load_w;

    // Ready whenever the output slot is empty or being drained this cycle.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Candidate results for every mode; the extra top bit carries the
    // carry (ADD), borrow (SUB) or accumulator overflow (ACC).
    assign add_w    = {1'b0, a} + {1'b0, b};
    assign sub_w    = {1'b0, a} - {1'b0, b};
    assign ext_a    = {{(ACC_WIDTH-WIDTH){1'b0}}, a};
    assign ext_b    = {{(ACC_WIDTH-WIDTH){1'b0}}, b};
    // A clear arriving with an ACC makes the accumulation start from zero.
    assign acc_base = clear ? '0 : acc_q;
    assign acc_w    = {1'b0, acc_base} + {1'b0, ext_a} + {1'b0, ext_b};
    assign load_w   = ext_a + ext_b;

    // Next-state selection: accept loads a new result, otherwise the result
    // is held until consumed and clear acts on the accumulator alone.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_WIDTH'(1);
            if (clear) begin
                acc_d = '0;
            end
            case (mode)
                MODE_ADD: begin
                    sum_d   = sat_sum(add_w[WIDTH], add_w[WIDTH-1:0], {WIDTH{1'b1}});
                    carry_d = add_w[WIDTH];
                end
                MODE_SUB: begin
                    sum_d   = sat_sum(sub_w[WIDTH], sub_w[WIDTH-1:0], {WIDTH{1'b0}});
                    carry_d = sub_w[WIDTH];
                end
                MODE_ACC: begin
                    acc_d   = sat_acc(acc_w[ACC_WIDTH], acc_w[ACC_WIDTH-1:0]);
                    sum_d   = sat_sum(acc_w[ACC_WIDTH], acc_w[WIDTH-1:0], {WIDTH{1'b1}});
                    carry_d = acc_w[ACC_WIDTH];
                end
                MODE_LOAD: begin
                    acc_d   = load_w;
                    sum_d   = load_w[WIDTH-1:0];
                    carry_d = 1'b0;
                end
                default: begin
                    sum_d = sum_q;
                end
            endcase
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (clear) begin
                acc_d = '0;
            end
        end
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign acc       = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_multi_mode_accum_adder.sv
// Scoreboard bench for multi_mode_accum_adder (WIDTH=8, ACC_WIDTH=12, CNT_WIDTH=8).
// Stimulus pushes expected results into a queue; a monitor pops them on each
// output handshake. Build with MULTI_MODE_ACCUM_ADDER_SATURATE_EN to check the
// saturating variant.
module tb_multi_mode_accum_adder;

    localparam int W  = 8;
    localparam int AW = 12;
    localparam int CW = 8;

`ifdef MULTI_MODE_ACCUM_ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int M_ADD  = 0;
    localparam int M_SUB  = 1;
    localparam int M_ACC  = 2;
    localparam int M_LOAD = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          carry;
    logic [AW-1:0] acc;
    logic [CW-1:0] op_count;

    typedef struct {
        int s;
        int c;
        int ac;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc_m = 0;
    int   cnt_m = 0;

    multi_mode_accum_adder #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry    (carry),
        .acc      (acc),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Reference behaviour for one accepted operation.
    task automatic model(input int ta, input int tb_v, input int tm, input bit tc,
                         output exp_t e);
        int r;
        if (tc) acc_m = 0;
        case (tm)
            M_ADD: begin
                r   = ta + tb_v;
                e.c = (r > 255) ? 1 : 0;
                e.s = (SAT && r > 255) ? 255 : r % 256;
            end
            M_SUB: begin
                e.c = (ta < tb_v) ? 1 : 0;
                if (ta < tb_v) e.s = SAT ? 0 : ta - tb_v + 256;
                else           e.s = ta - tb_v;
            end
            M_ACC: begin
                r   = acc_m + ta + tb_v;
                e.c = (r > 4095) ? 1 : 0;
                if (r > 4095) acc_m = SAT ? 4095 : r - 4096;
                else          acc_m = r;
                e.s = (SAT && r > 4095) ? 255 : r % 256;
            end
            default: begin
                acc_m = ta + tb_v;
                e.s   = (ta + tb_v) % 256;
                e.c   = 0;
            end
        endcase
        cnt_m = (cnt_m + 1) % 256;
        e.ac  = acc_m;
        e.cnt = cnt_m;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int ta, input int tb_v, input int tm, input bit tc);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        a        = W'(ta);
        b        = W'(tb_v);
        mode     = 2'(tm);
        clear    = tc;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            model(ta, tb_v, tm, tc, e);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        acc_m = 0;
        cnt_m = 0;
    endtask

    // Monitor: compare each consumed result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%0d, expected no output", sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_sum",      int'(sum),      e.s);
                chk("mon_carry",    int'(carry),    e.c);
                chk("mon_acc",      int'(acc),      e.ac);
                chk("mon_op_count", int'(op_count), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = '0;
        clear     = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum",       int'(sum),       0);
        chk("rst_carry",     int'(carry),     0);
        chk("rst_acc",       int'(acc),       0);
        chk("rst_op_count",  int'(op_count),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1: ADD with carry out
        issue(200, 100, M_ADD, 1'b0);
        chk("s1_out_valid", int'(out_valid), 1);
        chk("s1_sum",       int'(sum),       SAT ? 255 : 44);
        chk("s1_carry",     int'(carry),     1);
        chk("s1_op_count",  int'(op_count),  1);

        // 2: SUB with borrow
        issue(5, 7, M_SUB, 1'b0);
        chk("s2_sum",   int'(sum),   SAT ? 0 : 254);
        chk("s2_carry", int'(carry), 1);
        chk("s2_acc",   int'(acc),   0);

        // 3: clear then nine accumulations of 255+255
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        acc_m = 0;
        chk("s3_clear_acc", int'(acc), 0);
        for (int i = 1; i <= 9; i++) begin
            issue(255, 255, M_ACC, 1'b0);
            if (i == 3) begin
                chk("s3_acc3",   int'(acc),   1530);
                chk("s3_sum3",   int'(sum),   250);
                chk("s3_carry3", int'(carry), 0);
            end
        end
        chk("s3_acc9",   int'(acc),   SAT ? 4095 : 494);
        chk("s3_sum9",   int'(sum),   SAT ? 255 : 238);
        chk("s3_carry9", int'(carry), 1);

        // 4: backpressure holds the result and blocks input
        do_reset();
        issue(1, 2, M_ADD, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'd9;
        b         = 8'd9;
        mode      = 2'(M_ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s4_in_ready",  int'(in_ready),  0);
            chk("s4_out_valid", int'(out_valid), 1);
            chk("s4_sum_held",  int'(sum),       3);
            chk("s4_op_count",  int'(op_count),  1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(9, 9, M_ADD, 1'b0);
        chk("s4_sum_next", int'(sum),      18);
        chk("s4_op_count", int'(op_count), 2);

        // 5: clear coincident with ACC restarts from zero
        issue(50, 50, M_LOAD, 1'b0);
        chk("s5_load_acc",   int'(acc),   100);
        chk("s5_load_carry", int'(carry), 0);
        issue(3, 4, M_ACC, 1'b1);
        chk("s5_acc",   int'(acc),   7);
        chk("s5_sum",   int'(sum),   7);
        chk("s5_carry", int'(carry), 0);

        // 6: reset pulse with a pending result
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        acc_m = 0;
        for (int i = 0; i < 3; i++) issue(255, 255, M_ACC, 1'b0);
        chk("s6_pre_acc",       int'(acc),       1530);
        chk("s6_pre_out_valid", int'(out_valid), 1);
        do_reset();
        @(negedge clk);
        chk("s6_out_valid", int'(out_valid), 0);
        chk("s6_acc",       int'(acc),       0);
        chk("s6_sum",       int'(sum),       0);
        chk("s6_carry",     int'(carry),     0);
        chk("s6_op_count",  int'(op_count),  0);
        chk("s6_in_ready",  int'(in_ready),  1);

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
